// File: rtl/fp_div_exp_pipe.sv
// Exponent/special-case front stage of the FP divider: eff(a)-eff(b)+BIAS plus NaN/Inf/zero classification.
// Latency: exactly 2 cycles (S1 operand classify, S2 exponent sum and flags); throughput 1 per cycle.
// Backpressure: valid/ready both sides; a stalled S2 holds its outputs, and in_ready drops only when both stages are full and stalled.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready           operand handshake; dividend/divisor are {sign, exp, mant}; in_tag sideband
//   out_valid/out_ready         result handshake
//   res_exp                     signed raw exponent eff(a)-eff(b)+BIAS, EXP_WIDTH+2 bits
//   res_sign                    sign(a)^sign(b), forced 0 for NaN
//   is_nan/is_inf/is_zero       special-result class, priority NaN > Inf > zero
//   div_by_zero                 finite nonzero divided by zero
//   exp_ovf/exp_unf             raw exponent out of normal range (never set with a special)
//   out_tag                     in_tag of the same transaction
//   res_exp_sat                 saturated biased exponent, only when FP_DIV_EXP_SAT_EN is defined
module fp_div_exp_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int BIAS       = 2**(EXP_WIDTH-1)-1,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]   dividend,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]   divisor,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_WIDTH+1:0]            res_exp,
    output logic                            res_sign,
    output logic                            is_nan,
    output logic                            is_inf,
    output logic                            is_zero,
    output logic                            div_by_zero,
    output logic                            exp_ovf,
    output logic                            exp_unf,
    output logic [TAG_WIDTH-1:0]            out_tag
`ifdef FP_DIV_EXP_SAT_EN
    ,
    output logic [EXP_WIDTH-1:0]            res_exp_sat
`endif
);

    localparam int FP_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam logic signed [EXP_WIDTH+1:0] BIAS_X = (EXP_WIDTH+2)'(BIAS);
    localparam logic signed [EXP_WIDTH+1:0] OVF_TH = (EXP_WIDTH+2)'(2**EXP_WIDTH-1);

    typedef struct packed {
        logic                   a_zero;
        logic                   a_inf;
        logic                   a_nan;
        logic                   b_zero;
        logic                   b_inf;
        logic                   b_nan;
        logic                   sign;
        logic [EXP_WIDTH-1:0]   eff_a;
        logic [EXP_WIDTH-1:0]   eff_b;
        logic [TAG_WIDTH-1:0]   tag;
    } s1_t;

    typedef struct packed {
        logic [EXP_WIDTH+1:0]   res_exp;
        logic                   sign;
        logic                   nan;
        logic                   inf;
        logic                   zero;
        logic                   dbz;
        logic                   ovf;
        logic                   unf;
        logic [TAG_WIDTH-1:0]   tag;
    } s2_t;

    logic s1_v_q, s2_v_q;
    logic s1_adv, s2_adv;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- S1: classify operands, form effective exponents ----------------
    logic [EXP_WIDTH-1:0]  exp_a, exp_b;
    logic [MANT_WIDTH-1:0] mant_a, mant_b;

    always_comb begin
        exp_a  = dividend[FP_WIDTH-2 -: EXP_WIDTH];
        exp_b  = divisor[FP_WIDTH-2 -: EXP_WIDTH];
        mant_a = dividend[MANT_WIDTH-1:0];
        mant_b = divisor[MANT_WIDTH-1:0];

        s1_d        = '0;
        s1_d.a_zero = (exp_a == '0) && (mant_a == '0);
        s1_d.a_inf  = (exp_a == '1) && (mant_a == '0);
        s1_d.a_nan  = (exp_a == '1) && (mant_a != '0);
        s1_d.b_zero = (exp_b == '0) && (mant_b == '0);
        s1_d.b_inf  = (exp_b == '1) && (mant_b == '0);
        s1_d.b_nan  = (exp_b == '1) && (mant_b != '0);
        s1_d.sign   = dividend[FP_WIDTH-1] ^ divisor[FP_WIDTH-1];
        // Denormals behave as exponent 1; leading mantissa zeros are handled by the normaliser.
        s1_d.eff_a  = (exp_a == '0) ? EXP_WIDTH'(1) : exp_a;
        s1_d.eff_b  = (exp_b == '0) ? EXP_WIDTH'(1) : exp_b;
        s1_d.tag    = in_tag;
    end

    // ---------------- S2: exponent sum, special priority, range flags ----------------
    logic signed [EXP_WIDTH+1:0] raw;
    logic                        special;

    always_comb begin
        // Two extra bits cover the full eff range, so this difference never wraps.
        raw = $signed({2'b00, s1_q.eff_a}) - $signed({2'b00, s1_q.eff_b}) + BIAS_X;

        s2_d         = '0;
        s2_d.res_exp = raw;
        s2_d.tag     = s1_q.tag;
        s2_d.nan     = s1_q.a_nan || s1_q.b_nan || (s1_q.a_zero && s1_q.b_zero)
                    || (s1_q.a_inf && s1_q.b_inf);
        s2_d.inf     = !s2_d.nan && (s1_q.a_inf || s1_q.b_zero);
        // With NaN excluded, a zero divisor means a is finite nonzero unless a is inf.
        s2_d.dbz     = !s2_d.nan && s1_q.b_zero && !s1_q.a_inf;
        s2_d.zero    = !s2_d.nan && !s2_d.inf && (s1_q.a_zero || s1_q.b_inf);
        special      = s2_d.nan || s2_d.inf || s2_d.zero;
        s2_d.sign    = s2_d.nan ? 1'b0 : s1_q.sign;
        s2_d.ovf     = !special && (raw >= OVF_TH);
        s2_d.unf     = !special && (raw[EXP_WIDTH+1] || (raw == (EXP_WIDTH+2)'(0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
            s2_v_q <= 1'b0;
            s2_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) s2_q <= s2_d;
            end
        end
    end

`ifdef FP_DIV_EXP_SAT_EN
    logic [EXP_WIDTH-1:0] sat_d, sat_q;

    always_comb begin
        sat_d = s2_d.res_exp[EXP_WIDTH-1:0];
        if (s2_d.nan || s2_d.inf || s2_d.ovf) sat_d = '1;
        else if (s2_d.zero || s2_d.unf)       sat_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                sat_q <= '0;
        else if (s2_adv && s1_v_q) sat_q <= sat_d;
    end

    assign res_exp_sat = sat_q;
`endif

    assign out_valid   = s2_v_q;
    assign res_exp     = s2_q.res_exp;
    assign res_sign    = s2_q.sign;
    assign is_nan      = s2_q.nan;
    assign is_inf      = s2_q.inf;
    assign is_zero     = s2_q.zero;
    assign div_by_zero = s2_q.dbz;
    assign exp_ovf     = s2_q.ovf;
    assign exp_unf     = s2_q.unf;
    assign out_tag     = s2_q.tag;

endmodule

// File: tb/tb_fp_div_exp_pipe.sv
// Bench for fp_div_exp_pipe (default parameters: binary32 layout, 4-bit tag).
// Fixed vector table, hand-written latency/backpressure/reset sequences, then randomized traffic.
// A negedge monitor scores every delivered result against a behavioural model and checks stall stability and in_ready.
`timescale 1ns/1ps
module tb_fp_div_exp_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [9:0]  res_exp;
    logic        res_sign, is_nan, is_inf, is_zero, div_by_zero, exp_ovf, exp_unf;
    logic [3:0]  out_tag;
    logic [7:0]  sat_w;

    always #5 clk = ~clk;

    fp_div_exp_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_exp(res_exp), .res_sign(res_sign),
        .is_nan(is_nan), .is_inf(is_inf), .is_zero(is_zero), .div_by_zero(div_by_zero),
        .exp_ovf(exp_ovf), .exp_unf(exp_unf), .out_tag(out_tag)
`ifdef FP_DIV_EXP_SAT_EN
        , .res_exp_sat(sat_w)
`endif
    );
`ifndef FP_DIV_EXP_SAT_EN
    assign sat_w = 8'h00;
`endif

    typedef struct packed {
        logic [9:0] res_exp;
        logic       sign, nan, inf, zero, dbz, ovf, unf;
        logic [3:0] tag;
        logic [7:0] sat;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        res_t        exp;
    } vec_t;

    res_t act;
    assign act = {res_exp, res_sign, is_nan, is_inf, is_zero, div_by_zero, exp_ovf, exp_unf, out_tag, sat_w};

    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    res_t exp_q[$];
    bit   sb_en = 1'b0;
    bit   stall_prev = 1'b0;
    res_t held;
    int   n_push = 0;
    int   n_pop  = 0;

    task automatic check(input string name, input res_t got, input res_t want);
        tot_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, got, want);
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        tot_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %b required %b", name, got, want);
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        tot_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", name, got, want);
    endtask

    function automatic res_t mk(input logic [9:0] e, input logic s, nan, inf, zero, dbz, ovf, unf,
                                input logic [3:0] t, input logic [7:0] sat);
        res_t r;
        r = {e, s, nan, inf, zero, dbz, ovf, unf, t, sat};
`ifndef FP_DIV_EXP_SAT_EN
        r.sat = 8'h00;
`endif
        return r;
    endfunction

    // Reference: straight from the IEEE class rules with integer arithmetic.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        res_t r;
        int   ea, eb, raw;
        bit   az, ai, an, bz, bi, bn, sp;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        az  = (ea == 0)   && (a[22:0] == 0);
        ai  = (ea == 255) && (a[22:0] == 0);
        an  = (ea == 255) && (a[22:0] != 0);
        bz  = (eb == 0)   && (b[22:0] == 0);
        bi  = (eb == 255) && (b[22:0] == 0);
        bn  = (eb == 255) && (b[22:0] != 0);
        raw = ((ea == 0) ? 1 : ea) - ((eb == 0) ? 1 : eb) + 127;
        r         = '0;
        r.res_exp = raw[9:0];
        r.tag     = t;
        if (an || bn || (az && bz) || (ai && bi)) r.nan = 1'b1;
        else if (ai || bz) begin
            r.inf = 1'b1;
            r.dbz = !ai;
        end else if (az || bi) r.zero = 1'b1;
        sp     = r.nan || r.inf || r.zero;
        r.sign = r.nan ? 1'b0 : (a[31] ^ b[31]);
        if (!sp) begin
            r.ovf = (raw >= 255);
            r.unf = (raw <= 0);
        end
        if (r.nan || r.inf || r.ovf)  r.sat = 8'hFF;
        else if (r.zero || r.unf)     r.sat = 8'h00;
        else                          r.sat = raw[7:0];
`ifndef FP_DIV_EXP_SAT_EN
        r.sat = 8'h00;
`endif
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'h01;
            3:       e = 8'hFE;
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Scoreboard / protocol monitor. Inputs and out_ready change only just after a rising edge,
    // so values seen here are exactly what the next rising edge will sample.
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            chk1("in_ready", in_ready, !((exp_q.size() == 2) && !out_ready));
            if (stall_prev) begin
                chk1("stall_valid", out_valid, 1'b1);
                check("stall_stable", act, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_result: got tag %0d required no output", out_tag);
                end else begin
                    check("result", act, exp_q.pop_front());
                    n_pop++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(dividend, divisor, in_tag));
                n_push++;
            end
            stall_prev = out_valid && !out_ready;
            held       = act;
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk_int(name, exp_q.size(), 0);
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h40000000, 4'd3,  mk(10'h080, 0,0,0,0,0,0,0, 4'd3,  8'h80)};
        vecs[1]  = '{32'h00000001, 32'h3F800000, 4'd1,  mk(10'h001, 0,0,0,0,0,0,0, 4'd1,  8'h01)};
        vecs[2]  = '{32'h00800000, 32'h7F000000, 4'd2,  mk(10'h382, 0,0,0,0,0,0,1, 4'd2,  8'h00)};
        vecs[3]  = '{32'h7F000000, 32'h00800000, 4'd4,  mk(10'h17C, 0,0,0,0,0,1,0, 4'd4,  8'hFF)};
        vecs[4]  = '{32'hBF800000, 32'h00000000, 4'd5,  mk(10'h0FD, 1,0,1,0,1,0,0, 4'd5,  8'hFF)};
        vecs[5]  = '{32'h00000000, 32'h00000000, 4'd6,  mk(10'h07F, 0,1,0,0,0,0,0, 4'd6,  8'hFF)};
        vecs[6]  = '{32'h3F800000, 32'h7F800000, 4'd7,  mk(10'h3FF, 0,0,0,1,0,0,0, 4'd7,  8'h00)};
        vecs[7]  = '{32'h7F800000, 32'h7F800000, 4'd8,  mk(10'h07F, 0,1,0,0,0,0,0, 4'd8,  8'hFF)};
        vecs[8]  = '{32'hFFC00000, 32'h3F800000, 4'd9,  mk(10'h0FF, 0,1,0,0,0,0,0, 4'd9,  8'hFF)};
        vecs[9]  = '{32'h7F800000, 32'h00000000, 4'd10, mk(10'h17D, 0,0,1,0,0,0,0, 4'd10, 8'hFF)};
        vecs[10] = '{32'h00000000, 32'h7F800000, 4'd11, mk(10'h381, 0,0,0,1,0,0,0, 4'd11, 8'h00)};
        vecs[11] = '{32'h7F000000, 32'h3F000000, 4'd12, mk(10'h0FF, 0,0,0,0,0,1,0, 4'd12, 8'hFF)};
        vecs[12] = '{32'h7F000000, 32'h3F800000, 4'd13, mk(10'h0FE, 0,0,0,0,0,0,0, 4'd13, 8'hFE)};
        vecs[13] = '{32'h00800000, 32'h40000000, 4'd14, mk(10'h000, 0,0,0,0,0,0,1, 4'd14, 8'h00)};
        vecs[14] = '{32'hC0000000, 32'h40000000, 4'd15, mk(10'h07F, 1,0,0,0,0,0,0, 4'd15, 8'h7F)};
        vecs[15] = '{32'h3F800000, 32'h80000000, 4'd0,  mk(10'h0FD, 1,0,1,0,1,0,0, 4'd0,  8'hFF)};
        vecs[16] = '{32'h00000000, 32'h3F800000, 4'd1,  mk(10'h001, 0,0,0,1,0,0,0, 4'd1,  8'h00)};

        // Reset state
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        check("reset_fields", act, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sb_en = 1'b1;

        // Table vectors, one at a time, exact 2-cycle latency
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            dividend = vecs[i].a; divisor = vecs[i].b; in_tag = vecs[i].tag; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk1("lat1_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
            chk1("lat2_out_valid", out_valid, 1'b1);
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end
        drain("table_drain");

        // Backpressure: 6 back-to-back ops with out_ready toggling
        n_pop = 0;
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    bit got;
                    got = 1'b0;
                    @(posedge clk); #1;
                    dividend = rnd_fp(); divisor = rnd_fp(); in_tag = 4'(k + 1); in_valid = 1'b1;
                    for (int w = 0; w < 20 && !got; w++) begin
                        @(negedge clk);
                        if (in_ready) got = 1'b1;
                        else @(posedge clk);
                    end
                    if (!got) begin
                        tot_cnt++;
                        $display("FAIL bp_accept: op %0d never accepted, required acceptance within 20 cycles", k);
                    end
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain("bp_drain");
        chk_int("bp_delivered", n_pop, 6);

        // Reset with two ops in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        dividend = 32'h40C00000; divisor = 32'h40000000; in_tag = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_tag = 4'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("pre_reset_out_valid", out_valid, 1'b1);
        #2;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1("post_reset_no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        sb_en = 1'b1;
        dividend = 32'h7F000000; divisor = 32'h00800000; in_tag = 4'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk1("post_reset_lat1", out_valid, 1'b0);
        @(posedge clk); #1;
        chk1("post_reset_lat2", out_valid, 1'b1);
        check("post_reset_result", act, mk(10'h17C, 0,0,0,0,0,1,0, 4'd4, 8'hFF));
        drain("reset_drain");

        // Randomized traffic against the model
        begin
            int cyc;
            int target;
            cyc = 0;
            target = n_push + 300;
            while (n_push < target && cyc < 5000) begin
                @(posedge clk); #1;
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                dividend  = rnd_fp();
                divisor   = rnd_fp();
                in_tag    = 4'($urandom);
                cyc++;
            end
            chk1("rand_budget", (n_push >= target), 1'b1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
